rx_buf_wr_req_gen: RTL and testbench
====================================

RX_BUF_WR_REQ_GEN -- requirements
Module: rx_buf_wr_req_gen

Interface
REQ-001 Parameter BUF_PTR_W, default 16: circular-buffer pointer width in bytes; wraps modulo 2^BUF_PTR_W.
REQ-002 Parameter FLOWID_W, default tcp_pkg FLOWID_W: flow index width; the pointer table has 2^FLOWID_W entries.
REQ-003 Port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1: synchronous, active-low reset.
REQ-005 Ports src_rx_req_val (in, 1), src_rx_req_flowid (in, FLOWID_W), src_rx_req_size (in, MSG_DATA_SIZE_WIDTH), rx_src_req_rdy (out, 1): payload header from the RX engine.
REQ-006 Ports src_rx_data_val (in, 1), src_rx_data (in, NOC_DATA_WIDTH), rx_src_data_rdy (out, 1): payload lines.
REQ-007 Ports wr_buf_req_val (out, 1), wr_buf_req_flowid (out, FLOWID_W), wr_buf_req_wr_ptr (out, BUF_PTR_W), wr_buf_req_size (out, MSG_DATA_SIZE_WIDTH), wr_buf_req_rdy (in, 1): request to the downstream circular-buffer writer.
REQ-008 Ports wr_buf_data_val (out, 1), wr_buf_data (out, NOC_DATA_WIDTH), wr_buf_data_rdy (in, 1): data to the writer.
REQ-009 Ports wr_buf_done (in, 1), wr_buf_done_rdy (out, 1): write completion from the writer.
REQ-010 Ports ptr_init_val (in, 1), ptr_init_flowid (in, FLOWID_W), ptr_init_ptr (in, BUF_PTR_W): flow-setup pointer load; always accepted.
REQ-011 Ports commit_val (out, 1), commit_flowid (out, FLOWID_W), commit_ptr (out, BUF_PTR_W), commit_rdy (in, 1): new tail pointer notification.

Function
REQ-012 FSM states: IDLE, REQ, DATA, WAIT_DONE, COMMIT; one request in flight.
REQ-013 IDLE: rx_src_req_rdy=1. A transfer (val&rdy) latches flowid, size and table[flowid] as wr_ptr. Next state is REQ if size!=0, otherwise COMMIT (or IDLE without the macro).
REQ-014 REQ: wr_buf_req_val=1 with the latched fields. On handshake, the line count becomes ceil(size/(NOC_DATA_WIDTH/8)) and the FSM goes to DATA.
REQ-015 DATA: combinational passthrough. wr_buf_data_val=src_rx_data_val, rx_src_data_rdy=wr_buf_data_rdy, wr_buf_data=src_rx_data. Each transfer decrements the count; the transfer at count 1 goes to WAIT_DONE.
REQ-016 wr_buf_done_rdy=1 only in WAIT_DONE. On done: table[flowid] <= wr_ptr+size, truncated to BUF_PTR_W (natural wrap). Next state is COMMIT.
REQ-017 COMMIT: commit_val=1, commit_flowid=latched flowid, commit_ptr=updated pointer. Returns to IDLE on commit_rdy.
REQ-018 Outputs are registered or state-decoded except the REQ-015 passthrough. Minimum latency from header accept to wr_buf_req_val is 1 cycle.
REQ-019 ptr_init writes table[ptr_init_flowid] in any state.
REQ-020 If ptr_init and a done update hit the same entry in the same cycle, ptr_init wins.
REQ-021 If ptr_init hits the same flow in the same cycle as an IDLE header accept, the latched wr_ptr is ptr_init_ptr (bypass).
REQ-022 A size of 0 issues no downstream request and no data, and leaves the pointer unchanged.
REQ-023 Outside DATA: rx_src_data_rdy=0 and wr_buf_data_val=0.

Reset
REQ-024 While rst_n=0 at a clock edge: FSM goes to IDLE, the count clears, all table entries become 0, and all latched fields become 0.
REQ-025 During reset, every val/rdy output is 0, and data/field outputs are 0.
REQ-026 A reset mid-operation abandons the transfer with no commit. The table returns to zeros.

Configuration
REQ-027 Macro RX_BUF_COMMIT_EN.
- Defined: the COMMIT state and commit interface operate as in REQ-017.
- Undefined: the COMMIT state is not built, commit_val is tied 0, and WAIT_DONE/zero-size go directly to IDLE.

Verification
REQ-028 Init flow 3 to 0x0100, then a size-128 header (NOC_DATA_WIDTH=512) -> request wr_ptr=0x0100 size=128, 2 data lines, done, commit ptr=0x0180.
REQ-029 Init flow 1 to 0xFFF0 (BUF_PTR_W=16), then size 0x20 -> commit ptr=0x0010 (wrap).
REQ-030 Size 0 on flow 2 -> no wr_buf_req_val, commit ptr = unchanged table value.
REQ-031 Size 65 -> exactly 2 data lines. Random wr_buf_data_rdy/src_rx_data_val stalls -> no lost or duplicated lines.
REQ-032 ptr_init to flow 5 = 0x4000 in the same cycle as done for flow 5 -> table[5]=0x4000. Same-cycle init+accept -> latched wr_ptr=init value.
REQ-033 Assert rst_n=0 during DATA -> next cycle IDLE, all outputs 0, table zeroed. Build without RX_BUF_COMMIT_EN -> commit_val never asserts.

Source files
------------

// File: rtl/rx_buf_wr_req_gen.sv
// rx_buf_wr_req_gen: turns payload headers from the RX engine into write
// requests for a per-flow circular receive buffer. Keeps a tail pointer per
// flow, issues one request at a time, passes the payload lines through to the
// writer, and advances the flow's tail once the writer reports completion.
//
// Optional feature macro: RX_BUF_COMMIT_EN
//   defined   -> a COMMIT state publishes the new tail pointer on commit_*.
//   undefined -> no COMMIT state, commit_val stays 0, completion and
//                zero-size headers return straight to IDLE.
module rx_buf_wr_req_gen #(
    parameter int BUF_PTR_W           = 16,
    parameter int FLOWID_W            = 4,
    parameter int MSG_DATA_SIZE_WIDTH = 16,
    parameter int NOC_DATA_WIDTH      = 512
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // payload header from the RX engine
    input  logic                           src_rx_req_val,
    input  logic [FLOWID_W-1:0]            src_rx_req_flowid,
    input  logic [MSG_DATA_SIZE_WIDTH-1:0] src_rx_req_size,
    output logic                           rx_src_req_rdy,
    // payload lines from the RX engine
    input  logic                           src_rx_data_val,
    input  logic [NOC_DATA_WIDTH-1:0]      src_rx_data,
    output logic                           rx_src_data_rdy,
    // request to the circular-buffer writer
    output logic                           wr_buf_req_val,
    output logic [FLOWID_W-1:0]            wr_buf_req_flowid,
    output logic [BUF_PTR_W-1:0]           wr_buf_req_wr_ptr,
    output logic [MSG_DATA_SIZE_WIDTH-1:0] wr_buf_req_size,
    input  logic                           wr_buf_req_rdy,
    // payload lines to the writer
    output logic                           wr_buf_data_val,
    output logic [NOC_DATA_WIDTH-1:0]      wr_buf_data,
    input  logic                           wr_buf_data_rdy,
    // completion from the writer
    input  logic                           wr_buf_done,
    output logic                           wr_buf_done_rdy,
    // flow setup pointer load, always accepted
    input  logic                           ptr_init_val,
    input  logic [FLOWID_W-1:0]            ptr_init_flowid,
    input  logic [BUF_PTR_W-1:0]           ptr_init_ptr,
    // new tail pointer notification
    output logic                           commit_val,
    output logic [FLOWID_W-1:0]            commit_flowid,
    output logic [BUF_PTR_W-1:0]           commit_ptr,
    input  logic                           commit_rdy
);

    localparam int LINE_BYTES = NOC_DATA_WIDTH / 8;
    localparam int LINE_SH    = $clog2(LINE_BYTES);
    localparam int SZX_W      = MSG_DATA_SIZE_WIDTH + 1;
    localparam int CNT_W      = SZX_W - LINE_SH;
    localparam int NUM_FLOWS  = 1 << FLOWID_W;

`ifdef RX_BUF_COMMIT_EN
    typedef enum logic [2:0] {IDLE, REQ, DATA, WAIT_DONE, COMMIT} state_t;
    // where a finished (or empty) transfer goes next
    localparam state_t POST_XFER = COMMIT;
`else
    typedef enum logic [1:0] {IDLE, REQ, DATA, WAIT_DONE} state_t;
    localparam state_t POST_XFER = IDLE;
`endif

    state_t                         state_q, state_d;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [FLOWID_W-1:0]            flowid_q, flowid_d;
    logic [MSG_DATA_SIZE_WIDTH-1:0] size_q, size_d;
    logic [BUF_PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [BUF_PTR_W-1:0]           tbl_q [NUM_FLOWS];

    logic [BUF_PTR_W-1:0]           acc_ptr;
    logic [BUF_PTR_W-1:0]           sum_ptr;
    logic [SZX_W-1:0]               size_rnd;
    logic [CNT_W-1:0]               line_cnt;
    logic                           done_upd;

    // Pointer for a header accepted this cycle; a same-cycle init of the same
    // flow must be seen, so it bypasses the table.
    assign acc_ptr = (ptr_init_val && (ptr_init_flowid == src_rx_req_flowid)) ?
                     ptr_init_ptr : tbl_q[src_rx_req_flowid];

    // New tail: wraps naturally in the pointer width.
    assign sum_ptr = wr_ptr_q + BUF_PTR_W'(size_q);

    // Number of bus lines carrying size bytes (round up).
    assign size_rnd = {1'b0, size_q} + SZX_W'(LINE_BYTES - 1);
    assign line_cnt = CNT_W'(size_rnd >> LINE_SH);

`ifdef RX_BUF_COMMIT_EN
    logic [BUF_PTR_W-1:0] commit_ptr_q, commit_ptr_d;
`endif

    // Next-state logic and state-decoded handshakes / data passthrough
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        flowid_d        = flowid_q;
        size_d          = size_q;
        wr_ptr_d        = wr_ptr_q;
        done_upd        = 1'b0;
        rx_src_req_rdy  = 1'b0;
        wr_buf_req_val  = 1'b0;
        rx_src_data_rdy = 1'b0;
        wr_buf_data_val = 1'b0;
        wr_buf_data     = '0;
        wr_buf_done_rdy = 1'b0;
`ifdef RX_BUF_COMMIT_EN
        commit_ptr_d    = commit_ptr_q;
        commit_val      = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                rx_src_req_rdy = 1'b1;
                if (src_rx_req_val) begin
                    flowid_d = src_rx_req_flowid;
                    size_d   = src_rx_req_size;
                    wr_ptr_d = acc_ptr;
`ifdef RX_BUF_COMMIT_EN
                    // an empty payload commits the pointer it found
                    commit_ptr_d = acc_ptr;
`endif
                    state_d  = (src_rx_req_size != '0) ? REQ : POST_XFER;
                end
            end
            REQ: begin
                wr_buf_req_val = 1'b1;
                if (wr_buf_req_rdy) begin
                    cnt_d   = line_cnt;
                    state_d = DATA;
                end
            end
            DATA: begin
                wr_buf_data_val = src_rx_data_val;
                rx_src_data_rdy = wr_buf_data_rdy;
                wr_buf_data     = src_rx_data;
                if (src_rx_data_val && wr_buf_data_rdy) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                wr_buf_done_rdy = 1'b1;
                if (wr_buf_done) begin
                    done_upd = 1'b1;
`ifdef RX_BUF_COMMIT_EN
                    commit_ptr_d = sum_ptr;
`endif
                    state_d  = POST_XFER;
                end
            end
`ifdef RX_BUF_COMMIT_EN
            COMMIT: begin
                commit_val = 1'b1;
                if (commit_rdy) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase

        // Hold every handshake and the data path quiet while in reset.
        if (!rst_n) begin
            rx_src_req_rdy  = 1'b0;
            wr_buf_req_val  = 1'b0;
            rx_src_data_rdy = 1'b0;
            wr_buf_data_val = 1'b0;
            wr_buf_data     = '0;
            wr_buf_done_rdy = 1'b0;
`ifdef RX_BUF_COMMIT_EN
            commit_val      = 1'b0;
`endif
        end
    end

    // FSM, line counter and latched request fields
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            flowid_q <= '0;
            size_q   <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            flowid_q <= flowid_d;
            size_q   <= size_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Per-flow tail pointer table; a flow-setup load overrides a same-cycle
    // completion update of the same entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FLOWS; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            if (done_upd) begin
                tbl_q[flowid_q] <= sum_ptr;
            end
            if (ptr_init_val) begin
                tbl_q[ptr_init_flowid] <= ptr_init_ptr;
            end
        end
    end

    assign wr_buf_req_flowid = rst_n ? flowid_q : '0;
    assign wr_buf_req_wr_ptr = rst_n ? wr_ptr_q : '0;
    assign wr_buf_req_size   = rst_n ? size_q   : '0;

`ifdef RX_BUF_COMMIT_EN
    // Pointer published in COMMIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_ptr_q <= '0;
        end else begin
            commit_ptr_q <= commit_ptr_d;
        end
    end

    assign commit_flowid = rst_n ? flowid_q     : '0;
    assign commit_ptr    = rst_n ? commit_ptr_q : '0;
`else
    logic unused_commit_rdy;
    assign unused_commit_rdy = commit_rdy;
    assign commit_val        = 1'b0;
    assign commit_flowid     = '0;
    assign commit_ptr        = '0;
`endif

endmodule

// File: tb/tb_rx_buf_wr_req_gen.sv
// Bench for rx_buf_wr_req_gen: directed scenarios plus randomized headers,
// stalls and pointer loads, checked against a per-flow pointer table model.
module tb_rx_buf_wr_req_gen;

    localparam int NOC_W  = 512;
    localparam int LINE_B = NOC_W / 8;
    localparam int NFLOW  = 16;
    localparam int CW     = NOC_W;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              src_rx_req_val;
    logic [3:0]        src_rx_req_flowid;
    logic [15:0]       src_rx_req_size;
    logic              rx_src_req_rdy;
    logic              src_rx_data_val;
    logic [NOC_W-1:0]  src_rx_data;
    logic              rx_src_data_rdy;
    logic              wr_buf_req_val;
    logic [3:0]        wr_buf_req_flowid;
    logic [15:0]       wr_buf_req_wr_ptr;
    logic [15:0]       wr_buf_req_size;
    logic              wr_buf_req_rdy;
    logic              wr_buf_data_val;
    logic [NOC_W-1:0]  wr_buf_data;
    logic              wr_buf_data_rdy;
    logic              wr_buf_done;
    logic              wr_buf_done_rdy;
    logic              ptr_init_val;
    logic [3:0]        ptr_init_flowid;
    logic [15:0]       ptr_init_ptr;
    logic              commit_val;
    logic [3:0]        commit_flowid;
    logic [15:0]       commit_ptr;
    logic              commit_rdy;

    int errors = 0;
    int checks = 0;
    logic [15:0] model_tbl [NFLOW];

    always #5 clk = ~clk;

    rx_buf_wr_req_gen #(
        .BUF_PTR_W(16), .FLOWID_W(4), .MSG_DATA_SIZE_WIDTH(16), .NOC_DATA_WIDTH(NOC_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_rx_req_val(src_rx_req_val), .src_rx_req_flowid(src_rx_req_flowid),
        .src_rx_req_size(src_rx_req_size), .rx_src_req_rdy(rx_src_req_rdy),
        .src_rx_data_val(src_rx_data_val), .src_rx_data(src_rx_data),
        .rx_src_data_rdy(rx_src_data_rdy),
        .wr_buf_req_val(wr_buf_req_val), .wr_buf_req_flowid(wr_buf_req_flowid),
        .wr_buf_req_wr_ptr(wr_buf_req_wr_ptr), .wr_buf_req_size(wr_buf_req_size),
        .wr_buf_req_rdy(wr_buf_req_rdy),
        .wr_buf_data_val(wr_buf_data_val), .wr_buf_data(wr_buf_data),
        .wr_buf_data_rdy(wr_buf_data_rdy),
        .wr_buf_done(wr_buf_done), .wr_buf_done_rdy(wr_buf_done_rdy),
        .ptr_init_val(ptr_init_val), .ptr_init_flowid(ptr_init_flowid),
        .ptr_init_ptr(ptr_init_ptr),
        .commit_val(commit_val), .commit_flowid(commit_flowid),
        .commit_ptr(commit_ptr), .commit_rdy(commit_rdy)
    );

    task automatic check_val(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [NOC_W-1:0] rand_line();
        logic [NOC_W-1:0] v;
        v = '0;
        for (int i = 0; i < NOC_W / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    // OR of every DUT output, used to confirm the quiet-in-reset behaviour
    function automatic logic [CW-1:0] all_outs();
        return wr_buf_data | CW'({rx_src_req_rdy, rx_src_data_rdy, wr_buf_req_val,
                                  wr_buf_data_val, wr_buf_done_rdy, commit_val,
                                  wr_buf_req_flowid, wr_buf_req_wr_ptr, wr_buf_req_size,
                                  commit_flowid, commit_ptr});
    endfunction

    task automatic init_ptr(input logic [3:0] f, input logic [15:0] p);
        @(negedge clk);
        ptr_init_val = 1'b1; ptr_init_flowid = f; ptr_init_ptr = p;
        @(negedge clk);
        ptr_init_val = 1'b0;
        model_tbl[f] = p;
    endtask

    // One complete header -> request -> data -> done (-> commit) sequence.
    // ai_*: pointer load in the header-accept cycle; di_*: in the done cycle.
    task automatic run_txn(input logic [3:0] f, input logic [15:0] sz,
                           input bit ai_en, input logic [3:0] ai_f, input logic [15:0] ai_p,
                           input bit di_en, input logic [3:0] di_f, input logic [15:0] di_p);
        logic [15:0]      exp_ptr, exp_new;
        logic [NOC_W-1:0] lines [$];
        logic [NOC_W-1:0] rcvd [$];
        int               nlines, sent, waitc, k;
        bit               pass_err;

        @(negedge clk);
        src_rx_req_val = 1'b1; src_rx_req_flowid = f; src_rx_req_size = sz;
        if (ai_en) begin
            ptr_init_val = 1'b1; ptr_init_flowid = ai_f; ptr_init_ptr = ai_p;
        end
        #1;
        check_val("hdr_rdy", CW'(rx_src_req_rdy), CW'(1));
        exp_ptr = (ai_en && ai_f == f) ? ai_p : model_tbl[f];
        if (ai_en) model_tbl[ai_f] = ai_p;
        exp_new = exp_ptr + sz;
        @(negedge clk);
        src_rx_req_val = 1'b0; ptr_init_val = 1'b0;
        #1;

        if (sz == 16'd0) begin
            check_val("zs_no_req", CW'(wr_buf_req_val), CW'(0));
`ifdef RX_BUF_COMMIT_EN
            check_val("zs_commit_val", CW'(commit_val), CW'(1));
            check_val("zs_commit_flow", CW'(commit_flowid), CW'(f));
            check_val("zs_commit_ptr", CW'(commit_ptr), CW'(exp_ptr));
            commit_rdy = 1'b1;
            @(negedge clk);
            commit_rdy = 1'b0;
            #1;
`endif
            check_val("zs_idle", CW'(rx_src_req_rdy), CW'(1));
            return;
        end

        // request phase: visible one cycle after accept, held through stalls
        check_val("req_val", CW'(wr_buf_req_val), CW'(1));
        check_val("req_flow", CW'(wr_buf_req_flowid), CW'(f));
        check_val("req_ptr", CW'(wr_buf_req_wr_ptr), CW'(exp_ptr));
        check_val("req_size", CW'(wr_buf_req_size), CW'(sz));
        k = $urandom_range(0, 2);
        repeat (k) @(negedge clk);
        #1;
        check_val("req_hold", CW'(wr_buf_req_val), CW'(1));
        wr_buf_req_rdy = 1'b1;
        @(negedge clk);
        wr_buf_req_rdy = 1'b0;

        // data phase with random stalls on both sides
        nlines = (int'(sz) + LINE_B - 1) / LINE_B;
        for (int i = 0; i < nlines; i++) lines.push_back(rand_line());
        sent = 0; waitc = 0; pass_err = 1'b0;
        while (rcvd.size() < nlines && waitc < 400) begin
            src_rx_data_val = (sent < nlines) && ($urandom_range(0, 3) != 0);
            src_rx_data     = (sent < nlines) ? lines[sent] : '0;
            wr_buf_data_rdy = ($urandom_range(0, 3) != 0);
            #1;
            if (wr_buf_data_val !== src_rx_data_val || rx_src_data_rdy !== wr_buf_data_rdy)
                pass_err = 1'b1;
            if (wr_buf_data_val && wr_buf_data_rdy) rcvd.push_back(wr_buf_data);
            if (src_rx_data_val && rx_src_data_rdy) sent++;
            @(negedge clk);
            waitc++;
        end
        check_val("data_lines", CW'(rcvd.size()), CW'(nlines));
        check_val("data_passthru", CW'(pass_err), CW'(0));
        for (int i = 0; i < nlines && i < rcvd.size(); i++)
            check_val("data_line", rcvd[i], lines[i]);

        // no further lines may be taken once the count is exhausted
        src_rx_data_val = 1'b1; src_rx_data = rand_line(); wr_buf_data_rdy = 1'b1;
        #1;
        check_val("data_extra", CW'({rx_src_data_rdy, wr_buf_data_val}), CW'(0));
        check_val("done_rdy", CW'(wr_buf_done_rdy), CW'(1));
        src_rx_data_val = 1'b0; wr_buf_data_rdy = 1'b0;

        k = $urandom_range(0, 2);
        repeat (k) @(negedge clk);
        wr_buf_done = 1'b1;
        if (di_en) begin
            ptr_init_val = 1'b1; ptr_init_flowid = di_f; ptr_init_ptr = di_p;
        end
        @(negedge clk);
        wr_buf_done = 1'b0; ptr_init_val = 1'b0;
        model_tbl[f] = exp_new;
        if (di_en) model_tbl[di_f] = di_p;
        #1;
        check_val("done_rdy_low", CW'(wr_buf_done_rdy), CW'(0));
`ifdef RX_BUF_COMMIT_EN
        check_val("commit_val", CW'(commit_val), CW'(1));
        check_val("commit_flow", CW'(commit_flowid), CW'(f));
        check_val("commit_ptr", CW'(commit_ptr), CW'(exp_new));
        k = $urandom_range(0, 2);
        repeat (k) @(negedge clk);
        commit_rdy = 1'b1;
        @(negedge clk);
        commit_rdy = 1'b0;
        #1;
`else
        check_val("commit_off", CW'(commit_val), CW'(0));
`endif
        check_val("back_idle", CW'(rx_src_req_rdy), CW'(1));
    endtask

    task automatic txn(input logic [3:0] f, input logic [15:0] sz);
        run_txn(f, sz, 1'b0, 4'd0, 16'd0, 1'b0, 4'd0, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [15:0] sizes [9];
        logic [3:0]  rf, af, dfl;
        logic [15:0] rs;
        bit          ae, de;

        sizes[0] = 16'd0;   sizes[1] = 16'd1;   sizes[2] = 16'd63;
        sizes[3] = 16'd64;  sizes[4] = 16'd65;  sizes[5] = 16'd127;
        sizes[6] = 16'd128; sizes[7] = 16'd129; sizes[8] = 16'd300;
        for (int i = 0; i < NFLOW; i++) model_tbl[i] = 16'd0;

        // reset with busy-looking inputs: every output must stay 0
        rst_n = 1'b0;
        src_rx_req_val = 1'b1; src_rx_req_flowid = 4'd3; src_rx_req_size = 16'd64;
        src_rx_data_val = 1'b1; src_rx_data = rand_line(); wr_buf_data_rdy = 1'b1;
        wr_buf_req_rdy = 1'b1; wr_buf_done = 1'b1; commit_rdy = 1'b1;
        ptr_init_val = 1'b0; ptr_init_flowid = 4'd0; ptr_init_ptr = 16'd0;
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_outs", all_outs(), '0);
        src_rx_req_val = 1'b0; src_rx_data_val = 1'b0; wr_buf_data_rdy = 1'b0;
        wr_buf_req_rdy = 1'b0; wr_buf_done = 1'b0; commit_rdy = 1'b0;
        rst_n = 1'b1;
        #1;
        check_val("rst_idle_rdy", CW'(rx_src_req_rdy), CW'(1));

        // basic transfer, two lines
        init_ptr(4'd3, 16'h0100);
        txn(4'd3, 16'd128);
        txn(4'd3, 16'd10);
        // pointer wrap
        init_ptr(4'd1, 16'hFFF0);
        txn(4'd1, 16'h0020);
        txn(4'd1, 16'd64);
        // zero size leaves the pointer alone
        txn(4'd2, 16'd0);
        init_ptr(4'd2, 16'h1234);
        txn(4'd2, 16'd0);
        txn(4'd2, 16'd10);
        // partial last line
        txn(4'd4, 16'd65);
        // init wins over a same-cycle done on the same flow
        init_ptr(4'd5, 16'h2000);
        run_txn(4'd5, 16'd100, 1'b0, 4'd0, 16'd0, 1'b1, 4'd5, 16'h4000);
        txn(4'd5, 16'd1);
        // same-cycle init and header accept: bypass
        run_txn(4'd6, 16'd64, 1'b1, 4'd6, 16'h7777, 1'b0, 4'd0, 16'd0);
        txn(4'd6, 16'd64);
        run_txn(4'd7, 16'd10, 1'b1, 4'd8, 16'h0055, 1'b1, 4'd9, 16'h0909);
        txn(4'd8, 16'd1);
        txn(4'd9, 16'd1);

        // randomized traffic
        for (int n = 0; n < 30; n++) begin
            rf  = 4'($urandom_range(0, NFLOW - 1));
            rs  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 520))
                                              : sizes[$urandom_range(0, 8)];
            ae  = ($urandom_range(0, 3) == 0);
            de  = ($urandom_range(0, 3) == 0);
            af  = ($urandom_range(0, 1) == 0) ? rf : 4'($urandom_range(0, NFLOW - 1));
            dfl = ($urandom_range(0, 1) == 0) ? rf : 4'($urandom_range(0, NFLOW - 1));
            run_txn(rf, rs, ae, af, 16'($urandom()), de, dfl, 16'($urandom()));
        end

        // reset in the middle of the data phase
        @(negedge clk);
        src_rx_req_val = 1'b1; src_rx_req_flowid = 4'd3; src_rx_req_size = 16'd200;
        @(negedge clk);
        src_rx_req_val = 1'b0; wr_buf_req_rdy = 1'b1;
        @(negedge clk);
        wr_buf_req_rdy = 1'b0;
        src_rx_data_val = 1'b1; src_rx_data = rand_line(); wr_buf_data_rdy = 1'b1;
        #1;
        check_val("mid_data_val", CW'(wr_buf_data_val), CW'(1));
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_mid_outs", all_outs(), '0);
        rst_n = 1'b1;
        #1;
        check_val("rst_mid_idle", CW'(rx_src_req_rdy), CW'(1));
        check_val("rst_mid_nodata", CW'({wr_buf_data_val, rx_src_data_rdy, commit_val}), CW'(0));
        src_rx_data_val = 1'b0; wr_buf_data_rdy = 1'b0;
        for (int i = 0; i < NFLOW; i++) model_tbl[i] = 16'd0;
        txn(4'd3, 16'd64);
        txn(4'd5, 16'd1);
        txn(4'd1, 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
